// File: rtl/serial_pattern_gen.sv
// Serial stimulus source for a single-bit sequence detector: shifts a latched
// pattern out MSB first with optional repetitions and idle gaps, and counts z hits.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 0,
  parameter int HIT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [REP_W-1:0] repeat_i,
  input  logic             z_i,
  output logic             w_o,
  output logic             w_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [HIT_W-1:0] hit_count_o
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [REP_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic             w_q;
  logic             w_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [HIT_W-1:0] hit_q;

  logic [LEN_W-1:0] eff_len_d;
  logic [WIDTH-1:0] aligned_d;
  logic [HIT_W-1:0] hit_d;

  // The pattern is left-aligned on acceptance so the first bit is always the MSB.
  always_comb begin
    eff_len_d = (len_i > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_i;
    aligned_d = pattern_i << (LEN_W'(WIDTH) - eff_len_d);
    hit_d     = hit_q;
    if (busy_q && z_i && (hit_q != '1)) begin
      hit_d = hit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= '0;
    end else begin
      hit_q <= hit_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            hit_q <= '0;
            if ((eff_len_d != '0) && (repeat_i != '0)) begin
              state_q   <= S_SHIFT;
              pat_q     <= aligned_d;
              shreg_q   <= aligned_d << 1;
              w_q       <= aligned_d[WIDTH-1];
              w_valid_q <= 1'b1;
              busy_q    <= 1'b1;
              len_q     <= eff_len_d;
              cnt_q     <= eff_len_d - 1'b1;
              rep_q     <= repeat_i;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            w_q     <= shreg_q[WIDTH-1];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - 1'b1;
          end else if (rep_q != REP_W'(1)) begin
            rep_q <= rep_q - 1'b1;
            if (GAP > 0) begin
              state_q   <= S_GAP;
              gap_q     <= GAP_W'(GAP - 1);
              w_q       <= 1'b0;
              w_valid_q <= 1'b0;
            end else begin
              w_q     <= pat_q[WIDTH-1];
              shreg_q <= pat_q << 1;
              cnt_q   <= len_q - 1'b1;
            end
          end else begin
            state_q   <= S_DONE;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - 1'b1;
          end else begin
            state_q   <= S_SHIFT;
            w_q       <= pat_q[WIDTH-1];
            w_valid_q <= 1'b1;
            shreg_q   <= pat_q << 1;
            cnt_q     <= len_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign w_o         = w_q;
  assign w_valid_o   = w_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign hit_count_o = hit_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen: two instances (GAP=0 and GAP=2) share
// stimulus; expected bits and done pulses are queued and checked by a monitor.
module tb_serial_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [5:0] rep;
  logic       z;

  logic       w0, wv0, busy0, done0;
  logic [7:0] hit0;
  logic       w2, wv2, busy2, done2;
  logic [7:0] hit2;

  int cycle = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         isDone;
    logic       val;
    int         cyc;
    logic [7:0] hit;
  } ev_t;

  ev_t sb0[$];
  ev_t sb1[$];

  serial_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(6), .GAP(0), .HIT_W(8)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pattern_i(pattern),
    .len_i(len), .repeat_i(rep), .z_i(z),
    .w_o(w0), .w_valid_o(wv0), .busy_o(busy0), .done_o(done0), .hit_count_o(hit0)
  );

  serial_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(6), .GAP(2), .HIT_W(8)) dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .pattern_i(pattern),
    .len_i(len), .repeat_i(rep), .z_i(z),
    .w_o(w2), .w_valid_o(wv2), .busy_o(busy2), .done_o(done2), .hit_count_o(hit2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: pops one expected event whenever a DUT presents a bit or a done pulse.
  task automatic monitorDut(input int d, input logic wv, input logic w, input logic busy,
                            input logic done, input logic [7:0] hit);
    ev_t e;
    bit  have;
    if (!wv && w) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_w dut%0d cycle %0d: w=%0b while w_valid=0, required 0", d, cycle, w);
    end
    if (wv || done) begin
      checks++;
      have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
      if (!have) begin
        errors++;
        $display("[TB] FAIL unexpected_output dut%0d cycle %0d: w_valid=%0b done=%0b, required no output",
                 d, cycle, wv, done);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        if (wv && (e.isDone || w !== e.val || cycle != e.cyc || busy !== 1'b1)) begin
          errors++;
          $display("[TB] FAIL bit dut%0d: got w=%0b busy=%0b at cycle %0d, required isDone=%0b w=%0b busy=1 at cycle %0d",
                   d, w, busy, cycle, e.isDone, e.val, e.cyc);
        end else if (!wv && (!e.isDone || cycle != e.cyc || hit !== e.hit || busy !== 1'b0)) begin
          errors++;
          $display("[TB] FAIL done dut%0d: got done at cycle %0d hit=%0d busy=%0b, required isDone=%0b at cycle %0d hit=%0d busy=0",
                   d, cycle, hit, busy, e.isDone, e.cyc, e.hit);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitorDut(0, wv0, w0, busy0, done0, hit0);
    monitorDut(1, wv2, w2, busy2, done2, hit2);
  end

  task automatic pushEv(input int d, input bit isDone, input logic val, input int cyc, input logic [7:0] hit);
    ev_t e;
    e.isDone = isDone;
    e.val    = val;
    e.cyc    = cyc;
    e.hit    = hit;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Expected bit stream for a run accepted at the edge after cycle c; done cycles hand-computed.
  task automatic expectRun(input int c, input logic [7:0] pat, input int l, input int r,
                           input int doneG0, input int doneG2, input logic [7:0] hit);
    int eff;
    int t;
    int g;
    eff = (l > 8) ? 8 : l;
    for (int d = 0; d < 2; d++) begin
      g = (d == 0) ? 0 : 2;
      t = c + 1;
      if (eff != 0 && r != 0) begin
        for (int k = 0; k < r; k++) begin
          for (int i = 0; i < eff; i++) begin
            pushEv(d, 1'b0, pat[eff-1-i], t, 8'd0);
            t++;
          end
          if (k < r - 1) t += g;
        end
      end
      pushEv(d, 1'b1, 1'b0, c + ((d == 0) ? doneG0 : doneG2), hit);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input logic [3:0] l, input logic [5:0] r, output int c);
    @(negedge clk);
    pattern = pat;
    len     = l;
    rep     = r;
    start   = 1'b1;
    c       = cycle;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_w0"}, {31'd0, w0}, 32'd0);
    checkOutput({tag, "_wv0"}, {31'd0, wv0}, 32'd0);
    checkOutput({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
    checkOutput({tag, "_done0"}, {31'd0, done0}, 32'd0);
    checkOutput({tag, "_hit0"}, {24'd0, hit0}, 32'd0);
    checkOutput({tag, "_w2"}, {31'd0, w2}, 32'd0);
    checkOutput({tag, "_wv2"}, {31'd0, wv2}, 32'd0);
    checkOutput({tag, "_busy2"}, {31'd0, busy2}, 32'd0);
    checkOutput({tag, "_done2"}, {31'd0, done2}, 32'd0);
    checkOutput({tag, "_hit2"}, {24'd0, hit2}, 32'd0);
  endtask

  task automatic waitIdle(input string name);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      #1;
      if (sb0.size() == 0 && sb1.size() == 0) break;
    end
    if (n == 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s: pending events dut0=%0d dut2=%0d, required 0", name, sb0.size(), sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  initial begin
    int c;
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    rep     = '0;
    z       = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    // Single 4-bit pattern: 1,0,1,1 then done on cycle 5.
    applyStimulus(8'b0000_1011, 4'd4, 6'd1, c);
    expectRun(c, 8'b0000_1011, 4, 1, 5, 5, 8'd0);
    @(negedge clk) start = 1'b0;
    waitIdle("single");

    // 101 three times: back-to-back (done 10) vs two-cycle gaps (done 14).
    applyStimulus(8'b0000_0101, 4'd3, 6'd3, c);
    expectRun(c, 8'b0000_0101, 3, 3, 10, 14, 8'd0);
    @(negedge clk) start = 1'b0;
    waitIdle("repeat");

    // z high for exactly five busy edges.
    applyStimulus(8'hA5, 4'd8, 6'd1, c);
    expectRun(c, 8'hA5, 8, 1, 9, 9, 8'd5);
    @(negedge clk);
    start = 1'b0;
    z     = 1'b1;
    repeat (5) @(negedge clk);
    z = 1'b0;
    waitIdle("hits");
    @(negedge clk);
    #1;
    checkOutput("hit_hold0", {24'd0, hit0}, 32'd5);
    checkOutput("hit_hold2", {24'd0, hit2}, 32'd5);

    // New run clears the count; a mid-run start with new inputs is ignored.
    applyStimulus(8'h3C, 4'd4, 6'd2, c);
    expectRun(c, 8'h3C, 4, 2, 9, 11, 8'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("hit_clear0", {24'd0, hit0}, 32'd0);
    checkOutput("hit_clear2", {24'd0, hit2}, 32'd0);
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'hFF;
    len     = 4'd1;
    rep     = 6'd1;
    @(negedge clk) start = 1'b0;
    waitIdle("midstart");

    // z held high over 304 (GAP=0) / 378 (GAP=2) busy cycles saturates at 255.
    z = 1'b1;
    applyStimulus(8'h96, 4'd8, 6'd38, c);
    expectRun(c, 8'h96, 8, 38, 305, 379, 8'd255);
    @(negedge clk) start = 1'b0;
    waitIdle("saturate");
    z = 1'b0;

    // len=0 with start held: accepted, ignored in DONE, accepted again in IDLE.
    applyStimulus(8'hFF, 4'd0, 6'd3, c);
    expectRun(c, 8'hFF, 0, 3, 1, 1, 8'd0);
    expectRun(c, 8'hFF, 0, 3, 3, 3, 8'd0);
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitIdle("len0");

    applyStimulus(8'hFF, 4'd5, 6'd0, c);
    expectRun(c, 8'hFF, 5, 0, 1, 1, 8'd0);
    @(negedge clk) start = 1'b0;
    waitIdle("rep0");

    // len=12 clamps to all 8 bits.
    applyStimulus(8'b1100_1010, 4'd12, 6'd1, c);
    expectRun(c, 8'b1100_1010, 12, 1, 9, 9, 8'd0);
    @(negedge clk) start = 1'b0;
    waitIdle("clamp");

    // Reset on bit 2 of 4: run abandoned, no done pulse.
    applyStimulus(8'b0000_1011, 4'd4, 6'd1, c);
    pushEv(0, 1'b0, 1'b1, c + 1, 8'd0);
    pushEv(0, 1'b0, 1'b0, c + 2, 8'd0);
    pushEv(1, 1'b0, 1'b1, c + 1, 8'd0);
    pushEv(1, 1'b0, 1'b0, c + 2, 8'd0);
    @(negedge clk) start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    #1;
    checkAllZero("midreset");
    checkOutput("midreset_pending", sb0.size() + sb1.size(), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    applyStimulus(8'b0000_1011, 4'd4, 6'd1, c);
    expectRun(c, 8'b0000_1011, 4, 1, 5, 5, 8'd0);
    @(negedge clk) start = 1'b0;
    waitIdle("after_reset");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
